// File: rtl/barrel_shifter_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : barrel_shifter_pipe_if
// Brief     : Streaming operand/result bundle for barrel_shifter_pipe.
//             The master side drives operands and accepts results; the
//             slave side is the shifter itself.
// Options   : BARREL_SHIFTER_PIPE_LEFT_EN adds the per-beat dir signal.
// Revision  : 1.0 - initial release
// ============================================================================
interface barrel_shifter_pipe_if #(
  parameter int W = 8
);
  localparam int SW = $clog2(W);

  logic          in_vld;
  logic          in_rdy;
  logic [W-1:0]  a;
  logic [SW-1:0] amt;
  logic [1:0]    lar;
`ifdef BARREL_SHIFTER_PIPE_LEFT_EN
  logic          dir;
`endif
  logic          o_vld;
  logic          o_rdy;
  logic [W-1:0]  o;

`ifdef BARREL_SHIFTER_PIPE_LEFT_EN
  modport master (output in_vld, a, amt, lar, dir, o_rdy,
                  input  in_rdy, o_vld, o);
  modport slave  (input  in_vld, a, amt, lar, dir, o_rdy,
                  output in_rdy, o_vld, o);
`else
  modport master (output in_vld, a, amt, lar, o_rdy,
                  input  in_rdy, o_vld, o);
  modport slave  (input  in_vld, a, amt, lar, o_rdy,
                  output in_rdy, o_vld, o);
`endif
endinterface
`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shifter_pipe
// Brief    : Pipelined W-bit barrel shifter (logic / arithmetic / rotate),
//            one power-of-two shift step per stage, valid/ready on both
//            sides with full-rate streaming and backpressure.
// Options  : BARREL_SHIFTER_PIPE_LEFT_EN adds a per-beat direction input
//            (0 = right, 1 = left). Undefined: right shifts only.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_shifter_pipe #(
  parameter int W = 8
) (
  input  wire                  clk,
  input  wire                  rst_n,
  barrel_shifter_pipe_if.slave bus
);
  localparam int SW       = $clog2(W);
  // Stage k keeps the SW-k shift-amount bits it has not consumed yet; all
  // stages share one flat vector laid out back to back.
  localparam int AMT_BITS = SW * (SW + 1) / 2;

  // Each stage register holds the operand as it enters that stage's shift
  // step; the step itself is combinational on the register output.
  logic [SW-1:0][W-1:0] data_q, data_n, src_data, shf;
  logic [SW-1:0][1:0]   lar_q, lar_n, src_lar;
  logic [SW-1:0]        sign_q, sign_n, src_sign;
  logic [SW-1:0]        dir_q, dir_n, src_dir;
  logic [SW-1:0]        v_q, v_n, src_v;
  logic [SW-1:0]        adv;
  logic [AMT_BITS-1:0]  amt_q, amt_n;
  logic                 full_run;

  // One conditional shift by s positions with the mode-specific fill.
  function automatic logic [W-1:0] stage_shift(
    input logic [W-1:0] d,
    input logic         en,
    input logic [1:0]   mode,
    input logic         sgn,
    input logic         left,
    input int           s
  );
    logic [W-1:0] res;
    logic [W-1:0] hi_fill;
    hi_fill = ~({W{1'b1}} >> s);
    res     = d;
    if (en) begin
      if (left) begin
        // Left logic and left arithmetic are the same zero fill.
        res = mode[1] ? ((d << s) | (d >> (W - s))) : (d << s);
      end else begin
        case (mode)
          2'b00:   res = d >> s;
          2'b01:   res = (d >> s) | (sgn ? hi_fill : '0);
          default: res = (d >> s) | (d << (W - s));
        endcase
      end
    end
    return res;
  endfunction

  // A stage may load when some stage from it to the output is empty or the
  // output is being taken; this gives in_rdy a direct path from o_rdy.
  always_comb begin
    full_run = 1'b1;
    adv      = '0;
    for (int k = SW - 1; k >= 0; k--) begin
      full_run = full_run & v_q[k];
      adv[k]   = bus.o_rdy | !full_run;
    end
  end

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int OFF = k * SW - (k * (k - 1)) / 2;
    localparam int RW  = SW - k;
    logic [RW-1:0] src_amt;
    logic          load;

    if (k == 0) begin : g_head
      assign src_data[k] = bus.a;
      assign src_amt     = bus.amt;
      assign src_lar[k]  = bus.lar;
      assign src_sign[k] = bus.a[W-1];
      assign src_v[k]    = bus.in_vld;
`ifdef BARREL_SHIFTER_PIPE_LEFT_EN
      assign src_dir[k]  = bus.dir;
`else
      assign src_dir[k]  = 1'b0;
`endif
    end else begin : g_link
      localparam int OFF_P = (k - 1) * SW - ((k - 1) * (k - 2)) / 2;
      assign src_data[k] = shf[k-1];
      assign src_amt     = amt_q[OFF_P+1 +: RW];
      assign src_lar[k]  = lar_q[k-1];
      assign src_sign[k] = sign_q[k-1];
      assign src_v[k]    = v_q[k-1];
      assign src_dir[k]  = dir_q[k-1];
    end

    assign shf[k] = stage_shift(data_q[k], amt_q[OFF], lar_q[k], sign_q[k],
                                dir_q[k], 1 << k);

    // Payload only moves with a valid beat, so a stalled or drained stage
    // keeps what it had.
    assign load               = adv[k] & src_v[k];
    assign data_n[k]          = load ? src_data[k] : data_q[k];
    assign amt_n[OFF +: RW]   = load ? src_amt     : amt_q[OFF +: RW];
    assign lar_n[k]           = load ? src_lar[k]  : lar_q[k];
    assign sign_n[k]          = load ? src_sign[k] : sign_q[k];
    assign dir_n[k]           = load ? src_dir[k]  : dir_q[k];
    assign v_n[k]             = adv[k] ? src_v[k]  : v_q[k];
  end

  // Pipeline state: cleared asynchronously, otherwise takes the next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      amt_q  <= '0;
      lar_q  <= '0;
      sign_q <= '0;
      dir_q  <= '0;
      v_q    <= '0;
    end else begin
      data_q <= data_n;
      amt_q  <= amt_n;
      lar_q  <= lar_n;
      sign_q <= sign_n;
      dir_q  <= dir_n;
      v_q    <= v_n;
    end
  end

  assign bus.in_rdy = adv[0];
  assign bus.o_vld  = v_q[SW-1];
  // Result is forced to zero while no beat is presented.
  assign bus.o      = v_q[SW-1] ? shf[SW-1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_shifter_pipe
// Brief    : Self-checking bench for barrel_shifter_pipe (W=8 main, W=2 side)
//            with a bit-level reference model and a scoreboard queue.
// Options  : BARREL_SHIFTER_PIPE_LEFT_EN exercises left shifts as well.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_shifter_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrel_shifter_pipe_if #(.W(W)) bus ();
  barrel_shifter_pipe_if #(.W(2)) bus2 ();

  barrel_shifter_pipe #(.W(W)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  barrel_shifter_pipe #(.W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] o;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] seen_o[$];
  int         seen_c[$];
  logic       lat_chk    = 1'b0;
  logic       rand_rdy   = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_o     = '0;
  logic       dir_drv    = 1'b0;
  logic       cur_dir;

  // Bit i of the result comes from bit i+amt (right) or i-amt (left) of the
  // operand; positions that fall off the end take the mode's fill.
  function automatic logic [7:0] model(input logic [7:0] av, input int am,
                                       input logic [1:0] lr, input logic left);
    logic [7:0] r;
    int src;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (!left) begin
        src = i + am;
        if (src < 8)           r[i] = av[src];
        else if (lr == 2'b00)  r[i] = 1'b0;
        else if (lr == 2'b01)  r[i] = av[7];
        else                   r[i] = av[src-8];
      end else begin
        src = i - am;
        if (src >= 0)          r[i] = av[src];
        else if (lr[1])        r[i] = av[src+8];
        else                   r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure, changed just after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.o_rdy = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: every presented beat is checked against the oldest expected
  // beat; stalls must hold the output; accepted inputs enqueue model results.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold_vld", {31'd0, bus.o_vld}, 32'd1);
        chk("stall_hold_o", {24'd0, bus.o}, {24'd0, prev_o});
      end
      if (bus.o_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out: got beat o=%0h want no beat", bus.o);
        end else begin
          chk("o_vs_model", {24'd0, bus.o}, {24'd0, exp_q[0].o});
          if (lat_chk) chk("latency", cyc - exp_q[0].cyc, 32'd3);
          if (bus.o_rdy) begin
            seen_o.push_back(bus.o);
            seen_c.push_back(cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      stall_prev = bus.o_vld & !bus.o_rdy;
      prev_o     = bus.o;
`ifdef BARREL_SHIFTER_PIPE_LEFT_EN
      cur_dir = bus.dir;
`else
      cur_dir = dir_drv;
`endif
      if (bus.in_vld && bus.in_rdy)
        exp_q.push_back('{model(bus.a, int'(bus.amt), bus.lar, cur_dir), cyc});
    end
  end

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic drive_beat(input logic [7:0] av, input logic [2:0] am,
                            input logic [1:0] lr, input logic dr, output int waited);
    waited     = 0;
    bus.in_vld = 1'b1;
    bus.a      = av;
    bus.amt    = am;
    bus.lar    = lr;
    dir_drv    = dr;
`ifdef BARREL_SHIFTER_PIPE_LEFT_EN
    bus.dir    = dr;
`endif
    @(negedge clk);
    while (!bus.in_rdy && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_rdy) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_rdy=0 want 1");
    end
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
  endtask

  // Wait for the next presented beat, compare with a literal; ends at posedge+1.
  task automatic wait_out(input string nm, input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_vld && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.o_vld) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: o_vld=0 want 1", nm);
    end else begin
      chk(nm, {24'd0, bus.o}, {24'd0, exp});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] mode_exp   [4] = '{8'h12, 8'hF2, 8'hD2, 8'hD2};
    logic [7:0] stream_exp [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    logic [1:0] w2_exp     [4] = '{2'b01, 2'b11, 2'b01, 2'b01};
    logic [7:0] bp_exp     [4];
    logic [7:0] ra;
    logic [2:0] ram;
    logic [1:0] rlr;
    logic       rdr;
    int         w;

    rst_n       = 1'b0;
    bus.in_vld  = 1'b0; bus.a  = '0; bus.amt  = '0; bus.lar  = '0; bus.o_rdy  = 1'b1;
    bus2.in_vld = 1'b0; bus2.a = '0; bus2.amt = '0; bus2.lar = '0; bus2.o_rdy = 1'b1;
`ifdef BARREL_SHIFTER_PIPE_LEFT_EN
    bus.dir = 1'b0;
    bus2.dir = 1'b0;
`endif

    // Model anchors from hand-computed values.
    chk("model_r_logic", {24'd0, model(8'h96, 3, 2'b00, 1'b0)}, 32'h12);
    chk("model_r_arith", {24'd0, model(8'h96, 3, 2'b01, 1'b0)}, 32'hF2);
    chk("model_r_rot",   {24'd0, model(8'h96, 3, 2'b10, 1'b0)}, 32'hD2);
    chk("model_l_rot",   {24'd0, model(8'h96, 3, 2'b10, 1'b1)}, 32'hB4);

    // Reset state, during and right after reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_vld", {31'd0, bus.o_vld}, 32'd0);
    chk("rst_o", {24'd0, bus.o}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_o_vld", {31'd0, bus.o_vld}, 32'd0);
    chk("post_rst_o", {24'd0, bus.o}, 32'd0);
    chk("post_rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
    chk("post_rst_in_rdy_w2", {31'd0, bus2.in_rdy}, 32'd1);
    idle(1);

    // Mode check with latency tracking.
    lat_chk = 1'b1;
    for (int l = 0; l < 4; l++) begin
      drive_beat(8'h96, 3'd3, 2'(l), 1'b0, w);
      wait_out("mode_o", mode_exp[l]);
    end

    // Streaming arithmetic shifts at full rate.
    seen_o.delete(); seen_c.delete();
    for (int i = 0; i < 8; i++) begin
      drive_beat(8'h80, 3'(i), 2'b01, 1'b0, w);
      chk("stream_in_rdy", w, 32'd0);
    end
    idle(6);
    chk("stream_count", seen_o.size(), 32'd8);
    for (int i = 0; i < seen_o.size() && i < 8; i++) begin
      chk("stream_o", {24'd0, seen_o[i]}, {24'd0, stream_exp[i]});
      if (i > 0) chk("stream_gap", seen_c[i] - seen_c[i-1], 32'd1);
    end

    // Backpressure: fill three stages, stall five cycles, then release.
    lat_chk = 1'b0;
    seen_o.delete(); seen_c.delete();
    bus.o_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom); ram = 3'($urandom); rlr = 2'($urandom);
      bp_exp[i] = model(ra, int'(ram), rlr, 1'b0);
      drive_beat(ra, ram, rlr, 1'b0, w);
      chk("bp_fill_in_rdy", w, 32'd0);
    end
    ra = 8'($urandom); ram = 3'($urandom); rlr = 2'($urandom);
    bp_exp[3]  = model(ra, int'(ram), rlr, 1'b0);
    bus.in_vld = 1'b1; bus.a = ra; bus.amt = ram; bus.lar = rlr; dir_drv = 1'b0;
`ifdef BARREL_SHIFTER_PIPE_LEFT_EN
    bus.dir = 1'b0;
`endif
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_rdy_low", {31'd0, bus.in_rdy}, 32'd0);
      chk("bp_o_vld", {31'd0, bus.o_vld}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.o_rdy = 1'b1;
    @(negedge clk);
    chk("bp_in_rdy_release", {31'd0, bus.in_rdy}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    idle(6);
    chk("bp_count", seen_o.size(), 32'd4);
    for (int i = 0; i < seen_o.size() && i < 4; i++)
      chk("bp_order", {24'd0, seen_o[i]}, {24'd0, bp_exp[i]});

    // Asynchronous reset with three beats in flight.
    for (int i = 0; i < 3; i++) drive_beat(8'($urandom), 3'($urandom), 2'($urandom), 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_o_vld", {31'd0, bus.o_vld}, 32'd0);
    chk("midrst_o", {24'd0, bus.o}, 32'd0);
    chk("midrst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen_o.delete(); seen_c.delete();
    idle(6);
    chk("no_stale_beat", seen_o.size(), 32'd0);
    lat_chk = 1'b1;
    drive_beat(8'h01, 3'd1, 2'b10, 1'b0, w);
    wait_out("post_rst_beat", 8'h80);

    // amt = 0 passes the operand in every mode.
    for (int l = 0; l < 4; l++) begin
      drive_beat(8'hA5, 3'd0, 2'(l), 1'b0, w);
      wait_out("amt0_o", 8'hA5);
    end

`ifdef BARREL_SHIFTER_PIPE_LEFT_EN
    drive_beat(8'h96, 3'd3, 2'b00, 1'b1, w);
    wait_out("left_logic", 8'hB0);
    drive_beat(8'h96, 3'd3, 2'b01, 1'b1, w);
    wait_out("left_arith", 8'hB0);
    drive_beat(8'h96, 3'd3, 2'b10, 1'b1, w);
    wait_out("left_rot", 8'hB4);
`endif

    // W = 2 instance: single stage, one-cycle latency.
    for (int l = 0; l < 4; l++) begin
      bus2.a = 2'b10; bus2.amt = 1'b1; bus2.lar = 2'(l); bus2.in_vld = 1'b1;
      @(negedge clk);
      chk("w2_in_rdy", {31'd0, bus2.in_rdy}, 32'd1);
      @(posedge clk);
      #1;
      bus2.in_vld = 1'b0;
      @(negedge clk);
      chk("w2_o_vld", {31'd0, bus2.o_vld}, 32'd1);
      chk("w2_o", {30'd0, bus2.o}, {30'd0, w2_exp[l]});
      @(negedge clk);
      chk("w2_o_vld_drop", {31'd0, bus2.o_vld}, 32'd0);
      idle(1);
    end

    // Randomised traffic with random gaps and backpressure.
    lat_chk  = 1'b0;
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      ra = 8'($urandom); ram = 3'($urandom); rlr = 2'($urandom);
`ifdef BARREL_SHIFTER_PIPE_LEFT_EN
      rdr = 1'($urandom);
`else
      rdr = 1'b0;
`endif
      drive_beat(ra, ram, rlr, rdr, w);
    end
    rand_rdy  = 1'b0;
    bus.o_rdy = 1'b1;
    idle(10);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
